regfile_mp: RTL
===============

# regfile_mp

Parametrised register file with two asynchronous read ports, one synchronous write port, optional write-to-read bypass and a hardware clear sequencer. It is the next generation of the processor's 8 x 8-bit general register bank. It sits between the decode/operand-fetch stage (read addresses) and the ALU write-back path (write port). The clear sequencer lets the control unit zero the bank without a full reset.

## Interface
- DATA_W, 8, register width in bits.
- ADDR_W, 3, address width; the bank holds DEPTH = 2**ADDR_W registers.
- ZERO_REG, 0, when 1, register 0 is hardwired to zero: writes to it are discarded and reads return 0.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- reg_write  in  1  write enable.
- write_addr  in  ADDR_W  write address.
- write_data  in  DATA_W  write data.
- read_addr1  in  ADDR_W  port-1 read address.
- read_addr2  in  ADDR_W  port-2 read address.
- read_data1  out  DATA_W  port-1 read data, combinational.
- read_data2  out  DATA_W  port-2 read data, combinational.
- clear_req  in  1  request a bank clear; level-sampled in IDLE.
- clear_busy  out  1  clear in progress; writes are dropped while high.
- clear_done  out  1  one-cycle pulse when the clear completes.
- write_drop  out  1  registered pulse; a write was dropped in the previous cycle because clear_busy was high.

## Operation
- Reset: all registers go to 0, the FSM enters IDLE, the clear counter goes to 0, and clear_busy, clear_done and write_drop all go to 0.
- Write: at a rising edge, if reg_write=1 and clear_busy=0, then regs[write_addr] <= write_data. With ZERO_REG=1 a write to address 0 is discarded, and write_drop is not asserted for it.
- Read: read_dataN = regs[read_addrN]. With ZERO_REG=1, address 0 returns 0.
- Both ports may read the same address at the same time.
- FSM states:
  - IDLE: if clear_req=1, go to CLEAR and set the counter to 0.
  - CLEAR: regs[counter] <= 0 and the counter increments. When counter = DEPTH-1, go to DONE.
  - DONE: clear_done=1 for this cycle, then go to IDLE.
- clear_busy=1 exactly in state CLEAR.
- clear_req while in CLEAR or DONE is ignored and is not queued.
- clear_req and reg_write in the same IDLE cycle: the write commits at that edge, and the clear starts on the next cycle, so that register is later zeroed.
- A write dropped in CLEAR causes write_drop=1 in the following cycle.
- Reads during CLEAR return current contents. Registers with index below the counter already read 0.
- Reset asserted mid-clear: the clear aborts immediately, all registers are 0, and no clear_done is produced.
- Counter width is ADDR_W. Wrap-around is never reached because the FSM leaves CLEAR at DEPTH-1.

## Timing
- Write-to-read latency is 1 cycle: data is visible on the read port after the writing edge (the bypass removes this latency).
- clear_req high at edge k:
  - clear_busy is high from just after edge k until just after edge k+DEPTH.
  - Register i is zeroed at edge k+1+i.
  - clear_done is high during the cycle between edges k+DEPTH and k+DEPTH+1.
  - The earliest next clear is accepted at edge k+DEPTH+2.
- Total clear cost is DEPTH+1 cycles from acceptance to return to IDLE.

## Configuration
- REGFILE_BYPASS_EN defined: read port N returns write_data combinationally when all of the following hold in the same cycle: reg_write=1, clear_busy=0, write_addr = read_addrN, and the address is not the hardwired zero register.
- REGFILE_BYPASS_EN undefined: read ports return stored contents only. A same-cycle read of the address being written returns the old value.

## Structure
- Shared package regfile_pkg holds:
  - state enum {IDLE, CLEAR, DONE};
  - defaults for DATA_W and ADDR_W.
- One sub-module, regfile_clear_fsm. It holds the state register and counter and produces clear_busy, clear_done, clear_we and clear_addr.
- The top level owns the storage array, write arbitration (clear beats the external write), read muxes, bypass and write_drop.

## Test plan
- Reset, then write 0xA5 to R3 and 0x5A to R6; read R3/R6 on ports 1 and 2 on the next cycle -> 0xA5 and 0x5A. Before any write, reads of any register -> 0x00.
- Same-cycle read of R4 while writing 0x3C to R4 (old value 0x11) -> with REGFILE_BYPASS_EN, 0x3C; without it, 0x11 that cycle and 0x3C the next.
- Fill all 8 registers with 0xFF, pulse clear_req -> clear_busy high for 8 cycles, then clear_done for 1 cycle; all reads return 0x00; R5 reads 0x00 only after edge k+6.
- reg_write to R2 with 0x77 during CLEAR -> R2 stays as cleared, write_drop=1 the next cycle. clear_req held high during CLEAR -> no second clear.
- Assert rst at counter=3 mid-clear -> all registers are 0x00, clear_busy=0, no clear_done.
- ZERO_REG=1: write 0x99 to R0 -> R0 still reads 0x00 on both ports, write_drop stays 0, and the bypass does not forward the value.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default widths for the regfile_mp register bank.
package regfile_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks every register address once, then pulses done.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              clear_we,
    output logic [ADDR_W-1:0] clear_addr
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                // Hold the counter on the last address instead of wrapping.
                if (cnt_q == '1) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clear_busy = (state_q == CLEAR);
    assign clear_done = (state_q == DONE);
    assign clear_we   = clear_busy;
    assign clear_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// 2R/1W register bank with hardware clear sequencer.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              write_drop
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              drop_q, drop_d;
    logic              clear_we;
    logic [ADDR_W-1:0] clear_addr;
    logic              wr_zero;
    logic              ext_we;

    regfile_clear_fsm #(
        .ADDR_W(ADDR_W)
    ) u_clear_fsm (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .clear_busy(clear_busy),
        .clear_done(clear_done),
        .clear_we  (clear_we),
        .clear_addr(clear_addr)
    );

    assign wr_zero = ZERO_REG && (write_addr == '0);
    assign ext_we  = reg_write && !clear_busy && !wr_zero;
    assign drop_d  = reg_write && clear_busy && !wr_zero;

    // The clear sequencer always wins the single write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (clear_we) begin
            regs_q[clear_addr] <= '0;
        end else if (ext_we) begin
            regs_q[write_addr] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign write_drop = drop_q;

    always_comb begin
        read_data1 = regs_q[read_addr1];
        if (ZERO_REG && (read_addr1 == '0)) begin
            read_data1 = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (ext_we && (write_addr == read_addr1)) begin
            read_data1 = write_data;
        end
`endif
    end

    always_comb begin
        read_data2 = regs_q[read_addr2];
        if (ZERO_REG && (read_addr2 == '0)) begin
            read_data2 = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (ext_we && (write_addr == read_addr2)) begin
            read_data2 = write_data;
        end
`endif
    end

endmodule
